// File: rtl/vend_seq_ctrl.sv
// Drink dispenser sequencer: collects nickel/dime/quarter credit, runs the vend
// req/ack handshake and pays change back as dime-first coin pulses.
//
// state   | meaning
// IDLE    | no credit, waiting for a first coin
// COLLECT | credit below price, accepting coins or cancel
// VEND    | vend_req held until the dispenser acks
// CHANGE  | returning remaining credit, one coin per cycle
module vend_seq_ctrl #(
    parameter int PRICE_NK = 5,
    parameter int MAX_NK   = 15,
    parameter int CW       = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          n,
    input  logic          d,
    input  logic          q,
    input  logic          cancel,
    input  logic          vend_ack,
    output logic          vend_req,
    output logic          chg_n,
    output logic          chg_d,
    output logic          coin_rej,
    output logic          busy,
    output logic [CW-1:0] credit
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] VEND    = 2'd2;
    localparam logic [1:0] CHANGE  = 2'd3;

    localparam logic [CW-1:0] PRICE_C = CW'(PRICE_NK);
    localparam logic [CW:0]   PRICE_W = (CW+1)'(PRICE_NK);
    localparam logic [CW:0]   MAX_W   = (CW+1)'(MAX_NK);

    logic [1:0]    state, state_nx;
    logic [CW-1:0] credit_nx;
    logic [CW:0]   coin_val, sum;
    logic          coin_any, coin_one, coin_ok;
    logic          chg_n_nx, chg_d_nx, rej_nx;

    always_comb begin
        coin_any = n | d | q;
        // odd parity excludes two coins; n&d excludes the all-three case
        coin_one = (n ^ d ^ q) & ~(n & d);
        coin_val = q ? (CW+1)'(5) : (d ? (CW+1)'(2) : (CW+1)'(1));
        sum      = {1'b0, credit} + coin_val;
        coin_ok  = coin_one && ((state == IDLE) || (state == COLLECT)) && (sum <= MAX_W);
        rej_nx   = coin_any && !coin_ok;

        state_nx  = state;
        credit_nx = credit;
        chg_n_nx  = 1'b0;
        chg_d_nx  = 1'b0;

        case (state)
            IDLE, COLLECT: begin
                if (coin_ok) begin
                    credit_nx = sum[CW-1:0];
                    state_nx  = (sum >= PRICE_W) ? VEND : COLLECT;
                end
                // an accepted coin on the cancel cycle is refunded with the rest
                if ((state == COLLECT) && cancel)
                    state_nx = CHANGE;
            end
            VEND: begin
                if (vend_ack) begin
                    credit_nx = credit - PRICE_C;
                    state_nx  = (credit == PRICE_C) ? IDLE : CHANGE;
                end
            end
            CHANGE: begin
                if (credit >= CW'(2)) begin
                    chg_d_nx  = 1'b1;
                    credit_nx = credit - CW'(2);
                end else if (credit == CW'(1)) begin
                    chg_n_nx  = 1'b1;
                    credit_nx = credit - CW'(1);
                end
                if (credit_nx == '0)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            credit   <= '0;
            vend_req <= 1'b0;
            chg_n    <= 1'b0;
            chg_d    <= 1'b0;
            coin_rej <= 1'b0;
        end else begin
            state    <= state_nx;
            credit   <= credit_nx;
            vend_req <= (state_nx == VEND);
            chg_n    <= chg_n_nx;
            chg_d    <= chg_d_nx;
            coin_rej <= rej_nx;
        end
    end

    assign busy = (state == VEND) || (state == CHANGE);

endmodule

// File: tb/tb_vend_seq_ctrl.sv
// Directed bench for vend_seq_ctrl: one instance at price 5 and one at price 3
// share stimulus; each scenario checks the instance it targets.
module tb_vend_seq_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic n = 1'b0, d = 1'b0, q = 1'b0, cancel = 1'b0, vend_ack = 1'b0;

    logic       vr5, cn5, cd5, rj5, bz5;
    logic [4:0] cr5;
    logic       vr3, cn3, cd3, rj3, bz3;
    logic [4:0] cr3;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vend_seq_ctrl u_p5 (
        .clk(clk), .reset(reset), .n(n), .d(d), .q(q), .cancel(cancel),
        .vend_ack(vend_ack), .vend_req(vr5), .chg_n(cn5), .chg_d(cd5),
        .coin_rej(rj5), .busy(bz5), .credit(cr5)
    );

    vend_seq_ctrl #(.PRICE_NK(3)) u_p3 (
        .clk(clk), .reset(reset), .n(n), .d(d), .q(q), .cancel(cancel),
        .vend_ack(vend_ack), .vend_req(vr3), .chg_n(cn3), .chg_d(cd3),
        .coin_rej(rj3), .busy(bz3), .credit(cr3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input logic [2:0] ndq);
        {n, d, q} = ndq;
        tick();
        {n, d, q} = 3'b000;
    endtask

    task automatic ack();
        vend_ack = 1'b1;
        tick();
        vend_ack = 1'b0;
    endtask

    task automatic do_reset();
        {n, d, q, cancel, vend_ack} = 5'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        do_reset();
        chk("rst_credit", cr5, 0);
        chk("rst_vend_req", vr5, 0);
        chk("rst_busy", bz5, 0);
        chk("rst_chg", {cn5, cd5, rj5}, 0);

        // 1: n,d,d at price 5
        coin(3'b100); chk("t1_credit_n", cr5, 1);
        coin(3'b010); chk("t1_credit_nd", cr5, 3);
        chk("t1_no_req_early", vr5, 0);
        coin(3'b010); chk("t1_credit_ndd", cr5, 5);
        chk("t1_vend_req", vr5, 1);
        chk("t1_busy_vend", bz5, 1);
        ack();
        chk("t1_credit_after", cr5, 0);
        chk("t1_req_drop", vr5, 0);
        chk("t1_idle", bz5, 0);
        tick();
        chk("t1_no_change", {cn5, cd5}, 0);

        // 2: single quarter at price 3
        do_reset();
        coin(3'b001);
        chk("t2_vend_req", vr3, 1);
        chk("t2_credit", cr3, 5);
        ack();
        chk("t2_credit_after", cr3, 2);
        chk("t2_busy_change", bz3, 1);
        chk("t2_req_drop", vr3, 0);
        tick();
        chk("t2_chg_d", cd3, 1);
        chk("t2_chg_n", cn3, 0);
        chk("t2_credit_zero", cr3, 0);
        chk("t2_idle", bz3, 0);
        tick();
        chk("t2_chg_d_end", cd3, 0);

        // 3: dime then cancel
        do_reset();
        coin(3'b010);
        chk("t3_credit", cr5, 2);
        cancel = 1'b1; tick(); cancel = 1'b0;
        chk("t3_busy", bz5, 1);
        chk("t3_credit_hold", cr5, 2);
        chk("t3_req0", vr5, 0);
        tick();
        chk("t3_chg_d", cd5, 1);
        chk("t3_credit_zero", cr5, 0);
        chk("t3_req1", vr5, 0);
        tick();
        chk("t3_pulse_end", {cn5, cd5}, 0);
        chk("t3_idle", bz5, 0);

        // 4: two coins in one cycle
        do_reset();
        coin(3'b110);
        chk("t4_rej", rj5, 1);
        chk("t4_credit", cr5, 0);
        chk("t4_idle", bz5, 0);
        tick();
        chk("t4_rej_pulse", rj5, 0);
        coin(3'b100);
        chk("t4_still_idle_accepts", cr5, 1);

        // cancel in IDLE ignored
        do_reset();
        cancel = 1'b1; tick(); cancel = 1'b0;
        chk("idle_cancel_busy", bz5, 0);

        // cancel with a coin in the same cycle: refund includes the coin
        coin(3'b100);
        {d, cancel} = 2'b11; tick(); {d, cancel} = 2'b00;
        chk("cc_credit", cr5, 3);
        chk("cc_busy", bz5, 1);
        tick();
        chk("cc_dime", {cn5, cd5}, 2'b01);
        chk("cc_credit1", cr5, 1);
        tick();
        chk("cc_nickel", {cn5, cd5}, 2'b10);
        chk("cc_credit0", cr5, 0);
        chk("cc_idle", bz5, 0);

        // 5: ack withheld
        do_reset();
        coin(3'b001);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("t5_hold_%0d", i), vr5, 1);
        end
        coin(3'b001);
        chk("t5_rej", rj5, 1);
        chk("t5_credit", cr5, 5);
        chk("t5_req", vr5, 1);
        ack();
        chk("t5_credit_after", cr5, 0);
        chk("t5_idle", bz5, 0);

        // 6: reset during CHANGE with credit 3
        do_reset();
        coin(3'b100);
        coin(3'b010);
        cancel = 1'b1; tick(); cancel = 1'b0;
        chk("t6_change", bz5, 1);
        chk("t6_credit3", cr5, 3);
        #2 reset = 1'b0;
        #1;
        chk("t6_async_credit", cr5, 0);
        chk("t6_async_busy", bz5, 0);
        chk("t6_async_outs", {vr5, cn5, cd5, rj5}, 0);
        tick();
        reset = 1'b1;
        tick();
        chk("t6_credit_after", cr5, 0);
        chk("t6_idle", bz5, 0);
        chk("t6_no_change", {cn5, cd5}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
